weight_mem_banked_hs: RTL and testbench
=======================================

# weight_mem_banked_hs

Parametrised banked weight memory for the MAC array, successor to the fixed 4×4 weight wrapper. It stores weights in `N_BANKS` independent single-port-read/single-port-write banks, each `LANES` × `DATA_W` wide. Two access modes are supported: CNN (one bank row per read) and FC (all banks in parallel from a programmable FC base pointer). New relative to the previous generation: valid/ready handshakes on read request and read data, a 2-entry output buffer, CNN-vs-FC write arbitration, write/read bank-conflict stalling, and a stall counter.

## Interface
- `N_BANKS`, 4: number of banks, power of 2, ≥2; `B = log2(N_BANKS)`.
- `LANES`, 4: weights per bank row; `ROW_W = LANES*DATA_W`.
- `DATA_W`, 8: weight width (signed).
- `BANK_DEPTH`, 64: rows per bank, power of 2; `LA = log2(BANK_DEPTH)`.
- `ADDR_W`, `LA+2*B`: external address width.
- `MODE_CNN`, 1: `mode` encoding for CNN; any other value means FC.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `mode` in 3: access mode; sampled only at read accept.
- `bank_sel_pos` in `$clog2(ADDR_W+1)`: CNN bank field MSB+1 position.
- `fc_base` in `LA`: FC bank-local base row.
- `wr_cnn_en` in 1, `wr_cnn_addr` in `ADDR_W`, `wr_cnn_data` in `ROW_W`: CNN write port. Always accepted.
- `wr_fc_en` in 1, `wr_fc_addr` in `ADDR_W`, `wr_fc_data` in `ROW_W`: FC write port.
- `wr_fc_ready` out 1: FC write accepted this cycle.
- `rd_valid` in 1, `rd_ready` out 1: read request handshake.
- `rd_cnn_addr` in `ADDR_W`, `rd_fc_addr` in `ADDR_W`: read addresses.
- `out_valid` out 1, `out_ready` in 1: read data handshake.
- `out_data` out `N_BANKS*ROW_W`: read data.
- `out_is_fc` out 1: the data beat came from an FC read.
- `stall_cnt` out 16: saturating count of cycles with `rd_valid && !rd_ready`.

## Operation

**Address decode.**
- CNN: `P = max(bank_sel_pos, B)`.
  - bank = `addr[P-1 -: B]`.
  - local row = `addr[P-B-1:0]`, zero-extended or truncated to `LA` bits. For `P==B`, local row = 0.
- FC, with `lo = addr[B-1:0]`, `bank = addr[2B-1:B]`, `hi = addr >> 2B`:
  - Write: targets that `bank`; local row = `(fc_base + {hi, lo}) mod BANK_DEPTH`.
  - Read: targets every bank; each bank reads the same local row, computed with the same formula from `rd_fc_addr`.

**Writes.** A write commits at the clock edge of the cycle in which it is asserted.
- Writes to different banks in the same cycle both commit.
- Both writes to the same bank: CNN wins, `wr_fc_ready=0`, and the FC write does not commit. The FC master must hold it.
- `wr_fc_ready = !(wr_cnn_en && same bank)`, and is 1 when `wr_fc_en=0`.

**Read accept.** `rd_ready = !conflict && (occ + inflight < 2)`.
- `conflict` is any accepted write this cycle to a bank the request reads: the CNN bank, or any bank for FC.
- `occ` is the output FIFO count; `inflight` is the accept from the previous cycle.
- A request is accepted when `rd_valid && rd_ready`. `mode` is captured at accept.

**Read data.** Data appears in the FIFO one cycle after accept.
- CNN beat: bank row at `out_data[ROW_W-1:0]`, upper bits 0, `out_is_fc=0`.
- FC beat: bank k row at `out_data[k*ROW_W +: ROW_W]`, `out_is_fc=1`.
- Beats leave in accept order. A beat pops on `out_valid && out_ready`.
- Data is never lost or duplicated under back-pressure.

**Counter.** `stall_cnt` increments on each cycle with `rd_valid && !rd_ready` and saturates at `0xFFFF`.

**Reset.** `reset=0` immediately clears the FIFO, `inflight` and `stall_cnt`.
- Outputs under reset: `out_valid=0`, `out_data=0`, `out_is_fc=0`, `stall_cnt=0`.
- `rd_ready` and `wr_fc_ready` are combinational and follow the rules above (both 1 with no traffic).
- An in-flight read is discarded. Memory contents are not reset.

## Timing
- Read latency: accept at cycle t → `out_valid=1` at t+1, provided the FIFO is empty. This is registered SRAM-model latency.
- Same-bank write at t and read at t+1: the read returns the new data.
- Read and write to the same bank in one cycle cannot happen, because `conflict` stalls the read.
- Full throughput of 1 read/cycle holds while `out_ready=1`.
- With `out_ready=0`, at most 2 beats are buffered and `rd_ready` falls once `occ+inflight==2`.
- Pop and push in the same cycle keep `occ` unchanged.
- `rd_ready`, `wr_fc_ready` and the bank decode are combinational from inputs and state. All other outputs are registered.

## Test plan
- N_BANKS=4, LANES=4, BANK_DEPTH=64, bank_sel_pos=8: CNN-write `0x04030201` to addr `0x45` (bank 1, row 5). Then CNN-read `0x45` → `out_valid` 1 cycle after accept, `out_data[31:0]=0x04030201`, upper bits 0, `out_is_fc=0`.
- fc_base=16: FC-write `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444` to addrs `0x00`, `0x04`, `0x08`, `0x0C` (banks 0..3, row 16). Then FC-read `0x00` → `out_data = 0x44444444_33333333_22222222_11111111`, `out_is_fc=1`.
- CNN and FC writes to bank 2 in the same cycle → `wr_fc_ready=0`, CNN data stored. FC held one more cycle → committed next cycle.
- FC read with `rd_valid` held while a CNN write hits any bank → `rd_ready=0` that cycle, `stall_cnt` +1, accepted the following cycle with correct data.
- Back-pressure: `out_ready=0`, 4 CNN reads requested back-to-back → exactly 2 accepted, `rd_ready=0` afterwards. Release `out_ready` → beats come out in order, remaining reads then accepted, no loss.
- Reset asserted with 2 beats buffered → `out_valid=0` and `stall_cnt=0` immediately. After release, memory still returns earlier written data.

Source files
------------

// File: rtl/weight_mem_banked_hs_if.sv
// Bus bundle for the banked weight memory: write ports, read request/data handshakes, mode controls.
interface weight_mem_banked_hs_if #(
  parameter int N_BANKS    = 4,
  parameter int LANES      = 4,
  parameter int DATA_W     = 8,
  parameter int BANK_DEPTH = 64,
  parameter int ADDR_W     = $clog2(BANK_DEPTH) + 2 * $clog2(N_BANKS)
);
  localparam int LA    = $clog2(BANK_DEPTH);
  localparam int ROW_W = LANES * DATA_W;
  localparam int PW    = $clog2(ADDR_W + 1);

  logic [2:0]               mode;
  logic [PW-1:0]            bank_sel_pos;
  logic [LA-1:0]            fc_base;
  logic                     wr_cnn_en;
  logic [ADDR_W-1:0]        wr_cnn_addr;
  logic [ROW_W-1:0]         wr_cnn_data;
  logic                     wr_fc_en;
  logic [ADDR_W-1:0]        wr_fc_addr;
  logic [ROW_W-1:0]         wr_fc_data;
  logic                     wr_fc_ready;
  logic                     rd_valid;
  logic                     rd_ready;
  logic [ADDR_W-1:0]        rd_cnn_addr;
  logic [ADDR_W-1:0]        rd_fc_addr;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_BANKS*ROW_W-1:0] out_data;
  logic                     out_is_fc;
  logic [15:0]              stall_cnt;

  modport master (
    output mode, bank_sel_pos, fc_base,
    output wr_cnn_en, wr_cnn_addr, wr_cnn_data,
    output wr_fc_en, wr_fc_addr, wr_fc_data,
    output rd_valid, rd_cnn_addr, rd_fc_addr, out_ready,
    input  wr_fc_ready, rd_ready, out_valid, out_data, out_is_fc, stall_cnt
  );

  modport slave (
    input  mode, bank_sel_pos, fc_base,
    input  wr_cnn_en, wr_cnn_addr, wr_cnn_data,
    input  wr_fc_en, wr_fc_addr, wr_fc_data,
    input  rd_valid, rd_cnn_addr, rd_fc_addr, out_ready,
    output wr_fc_ready, rd_ready, out_valid, out_data, out_is_fc, stall_cnt
  );
endinterface

// File: rtl/weight_mem_banked_hs.sv
// Banked weight memory with CNN/FC access modes, handshaked reads and a 2-entry output buffer.
// Read latency 1 cycle into the output stage; reads stall on bank-write conflicts or when 2 beats are held.
module weight_mem_banked_hs #(
  parameter int         N_BANKS    = 4,
  parameter int         LANES      = 4,
  parameter int         DATA_W     = 8,
  parameter int         BANK_DEPTH = 64,
  parameter int         ADDR_W     = $clog2(BANK_DEPTH) + 2 * $clog2(N_BANKS),
  parameter logic [2:0] MODE_CNN   = 3'd1
) (
  input logic             clk,
  input logic             reset,
  weight_mem_banked_hs_if.slave bus
);
  localparam int B     = $clog2(N_BANKS);
  localparam int LA    = $clog2(BANK_DEPTH);
  localparam int ROW_W = LANES * DATA_W;
  localparam int OUT_W = N_BANKS * ROW_W;
  localparam int PW    = $clog2(ADDR_W + 1);

  logic [ROW_W-1:0] r_mem [N_BANKS][BANK_DEPTH];

  // Returns {bank, local_row}; bank field sits just below bit position p.
  function automatic logic [B+LA-1:0] cnn_dec(input logic [ADDR_W-1:0] a, input logic [PW-1:0] p);
    logic [ADDR_W-1:0] sh;
    logic [ADDR_W-1:0] msk;
    sh  = a >> (p - PW'(B));
    msk = ~({ADDR_W{1'b1}} << (p - PW'(B)));
    return {B'(sh), LA'(a & msk)};
  endfunction

  // FC row skips the bank field: row = fc_base + {hi, lo}, wrapping at BANK_DEPTH.
  function automatic logic [LA-1:0] fc_row(input logic [ADDR_W-1:0] a, input logic [LA-1:0] base);
    logic [ADDR_W-1:0] hl;
    hl = ((a >> (2 * B)) << B) | (a & ADDR_W'(N_BANKS - 1));
    return base + LA'(hl);
  endfunction

  logic [PW-1:0]    w_p;
  logic [B-1:0]     w_wc_bank, w_wf_bank, w_rc_bank;
  logic [LA-1:0]    w_wc_row, w_wf_row, w_rc_row, w_rf_row;
  logic             w_fc_blk, w_fc_commit;
  logic [N_BANKS-1:0] w_we;
  logic [LA-1:0]    w_wrow [N_BANKS];
  logic [ROW_W-1:0] w_wdat [N_BANKS];
  logic             w_rd_fc, w_conflict, w_rd_ready, w_accept;
  logic [OUT_W-1:0] w_beat;
  logic             w_bypass, w_push, w_pop;

  logic             r_inflight;
  logic [OUT_W-1:0] r_rd_dat;
  logic             r_rd_fc;
  logic [OUT_W-1:0] r_fifo_dat [2];
  logic             r_fifo_fc  [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_occ;
  logic [15:0]      r_stall;

  assign w_p = (bus.bank_sel_pos < PW'(B)) ? PW'(B) : bus.bank_sel_pos;
  assign {w_wc_bank, w_wc_row} = cnn_dec(bus.wr_cnn_addr, w_p);
  assign {w_rc_bank, w_rc_row} = cnn_dec(bus.rd_cnn_addr, w_p);
  assign w_wf_bank = bus.wr_fc_addr[2*B-1:B];
  assign w_wf_row  = fc_row(bus.wr_fc_addr, bus.fc_base);
  assign w_rf_row  = fc_row(bus.rd_fc_addr, bus.fc_base);

  assign w_fc_blk    = bus.wr_fc_en && bus.wr_cnn_en && (w_wc_bank == w_wf_bank);
  assign w_fc_commit = bus.wr_fc_en && !w_fc_blk;
  assign bus.wr_fc_ready = !w_fc_blk;

  // CNN port overrides FC on a shared bank.
  always_comb begin
    for (int k = 0; k < N_BANKS; k++) begin
      w_we[k]   = 1'b0;
      w_wrow[k] = w_wf_row;
      w_wdat[k] = bus.wr_fc_data;
      if (w_fc_commit && (w_wf_bank == B'(k))) begin
        w_we[k] = 1'b1;
      end
      if (bus.wr_cnn_en && (w_wc_bank == B'(k))) begin
        w_we[k]   = 1'b1;
        w_wrow[k] = w_wc_row;
        w_wdat[k] = bus.wr_cnn_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_BANKS; k++) begin
      if (w_we[k]) begin
        r_mem[k][w_wrow[k]] <= w_wdat[k];
      end
    end
  end

  assign w_rd_fc    = (bus.mode != MODE_CNN);
  assign w_conflict = w_rd_fc ? (|w_we) : w_we[w_rc_bank];
  assign w_rd_ready = !w_conflict && ((r_occ + {1'b0, r_inflight}) < 2'd2);
  assign w_accept   = bus.rd_valid && w_rd_ready;
  assign bus.rd_ready = w_rd_ready;

  always_comb begin
    w_beat = '0;
    if (w_rd_fc) begin
      for (int k = 0; k < N_BANKS; k++) begin
        w_beat[k*ROW_W +: ROW_W] = r_mem[k][w_rf_row];
      end
    end else begin
      w_beat[ROW_W-1:0] = r_mem[w_rc_bank][w_rc_row];
    end
  end

  // The read register feeds the output directly when the buffer is empty and the sink is ready.
  assign w_bypass = r_inflight && (r_occ == 2'd0) && bus.out_ready;
  assign w_push   = r_inflight && !w_bypass;
  assign w_pop    = (r_occ != 2'd0) && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_rd_dat   <= '0;
      r_rd_fc    <= 1'b0;
      r_wptr     <= 1'b0;
      r_rptr     <= 1'b0;
      r_occ      <= 2'd0;
      r_stall    <= 16'd0;
      for (int k = 0; k < 2; k++) begin
        r_fifo_dat[k] <= '0;
        r_fifo_fc[k]  <= 1'b0;
      end
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_rd_dat <= w_beat;
        r_rd_fc  <= w_rd_fc;
      end
      if (w_push) begin
        r_fifo_dat[r_wptr] <= r_rd_dat;
        r_fifo_fc[r_wptr]  <= r_rd_fc;
        r_wptr             <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
      if (bus.rd_valid && !w_rd_ready && (r_stall != 16'hFFFF)) begin
        r_stall <= r_stall + 16'd1;
      end
    end
  end

  assign bus.out_valid = (r_occ != 2'd0) || r_inflight;
  assign bus.out_data  = (r_occ != 2'd0) ? r_fifo_dat[r_rptr] : r_rd_dat;
  assign bus.out_is_fc = (r_occ != 2'd0) ? r_fifo_fc[r_rptr]  : r_rd_fc;
  assign bus.stall_cnt = r_stall;
endmodule

// File: tb/tb_weight_mem_banked_hs.sv
// Scoreboarded bench for weight_mem_banked_hs: CNN/FC access, write arbitration, stalls, back-pressure, reset.
module tb_weight_mem_banked_hs;
  logic clk;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_stall = 0;

  weight_mem_banked_hs_if #(.N_BANKS(4), .LANES(4), .DATA_W(8), .BANK_DEPTH(64)) bus ();

  weight_mem_banked_hs #(.N_BANKS(4), .LANES(4), .DATA_W(8), .BANK_DEPTH(64), .MODE_CNN(3'd1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  mdl [4][64];
  logic [128:0] sb [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] cnn_bank(input logic [9:0] a); return a[7:6]; endfunction
  function automatic logic [5:0] cnn_row(input logic [9:0] a);  return a[5:0]; endfunction
  function automatic logic [1:0] fc_bank(input logic [9:0] a);  return a[3:2]; endfunction
  function automatic logic [5:0] fc_row(input logic [9:0] a, input logic [5:0] base);
    logic [7:0] hl;
    hl = {a[9:4], a[1:0]};
    return base + hl[5:0];
  endfunction

  // Reference model: reads see the memory before this cycle's writes commit.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      exp_stall = 0;
    end else begin
      logic [3:0]   we;
      logic         fc_ok, rd_fc;
      logic [5:0]   r;
      logic [128:0] e;
      logic [1:0]   cb;
      we    = 4'b0;
      fc_ok = !(bus.wr_fc_en && bus.wr_cnn_en && (cnn_bank(bus.wr_cnn_addr) == fc_bank(bus.wr_fc_addr)));
      if (bus.wr_fc_en) chk("wr_fc_ready", {127'b0, bus.wr_fc_ready}, {127'b0, fc_ok});
      if (bus.wr_cnn_en) we[cnn_bank(bus.wr_cnn_addr)] = 1'b1;
      if (bus.wr_fc_en && fc_ok) we[fc_bank(bus.wr_fc_addr)] = 1'b1;

      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra_beat", {127'b0, bus.out_valid}, 128'd0);
        end else begin
          e = sb.pop_front();
          chk("beat_data", bus.out_data, e[127:0]);
          chk("beat_is_fc", {127'b0, bus.out_is_fc}, {127'b0, e[128]});
        end
      end

      rd_fc = (bus.mode != 3'd1);
      cb    = cnn_bank(bus.rd_cnn_addr);
      if (bus.rd_valid && (rd_fc ? (|we) : we[cb]))
        chk("rd_conflict", {127'b0, bus.rd_ready}, 128'd0);
      if (bus.rd_valid && !bus.rd_ready) exp_stall++;
      if (bus.rd_valid && bus.rd_ready) begin
        if (rd_fc) begin
          r = fc_row(bus.rd_fc_addr, bus.fc_base);
          e = {1'b1, mdl[3][r], mdl[2][r], mdl[1][r], mdl[0][r]};
        end else begin
          e = {1'b0, 96'b0, mdl[cb][cnn_row(bus.rd_cnn_addr)]};
        end
        sb.push_back(e);
      end

      if (bus.wr_fc_en && fc_ok)
        mdl[fc_bank(bus.wr_fc_addr)][fc_row(bus.wr_fc_addr, bus.fc_base)] = bus.wr_fc_data;
      if (bus.wr_cnn_en)
        mdl[cnn_bank(bus.wr_cnn_addr)][cnn_row(bus.wr_cnn_addr)] = bus.wr_cnn_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cnn_wr(input logic [9:0] a, input logic [31:0] d);
    bus.wr_cnn_en = 1'b1; bus.wr_cnn_addr = a; bus.wr_cnn_data = d;
    tick();
    bus.wr_cnn_en = 1'b0;
  endtask

  task automatic fc_wr(input logic [9:0] a, input logic [31:0] d);
    bus.wr_fc_en = 1'b1; bus.wr_fc_addr = a; bus.wr_fc_data = d;
    tick();
    bus.wr_fc_en = 1'b0;
  endtask

  // Returns one cycle after the accepting edge, when the beat is at the output.
  task automatic rd_req(input logic [2:0] m, input logic [9:0] ca, input logic [9:0] fa);
    logic acc;
    int   n;
    bus.rd_valid = 1'b1; bus.mode = m; bus.rd_cnn_addr = ca; bus.rd_fc_addr = fa;
    acc = 1'b0;
    n   = 0;
    do begin
      @(negedge clk);
      acc = bus.rd_ready;
      tick();
      n++;
    end while (!acc && n < 100);
    bus.rd_valid = 1'b0;
    if (!acc) chk("rd_timeout", {127'b0, acc}, 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tick();
    chk("drain", 128'(sb.size()), 128'd0);
  endtask

  logic [9:0] addrs [4];
  int         idx;

  initial begin
    reset = 1'b0;
    bus.mode = 3'd1; bus.bank_sel_pos = 4'd8; bus.fc_base = 6'd16;
    bus.wr_cnn_en = 1'b0; bus.wr_cnn_addr = '0; bus.wr_cnn_data = '0;
    bus.wr_fc_en = 1'b0; bus.wr_fc_addr = '0; bus.wr_fc_data = '0;
    bus.rd_valid = 1'b0; bus.rd_cnn_addr = '0; bus.rd_fc_addr = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_is_fc", {127'b0, bus.out_is_fc}, 128'd0);
    chk("rst_stall", 128'(bus.stall_cnt), 128'd0);
    chk("rst_rd_ready", {127'b0, bus.rd_ready}, 128'd1);
    chk("rst_wr_fc_ready", {127'b0, bus.wr_fc_ready}, 128'd1);
    tick();
    reset = 1'b1;
    tick();

    // CNN write/read, one-cycle latency
    cnn_wr(10'h045, 32'h04030201);
    rd_req(3'd1, 10'h045, 10'h000);
    chk("cnn_latency", {127'b0, bus.out_valid}, 128'd1);
    chk("cnn_data", bus.out_data, 128'h04030201);
    chk("cnn_is_fc", {127'b0, bus.out_is_fc}, 128'd0);

    // FC writes to row 16 of each bank, then FC read
    fc_wr(10'h000, 32'h11111111);
    fc_wr(10'h004, 32'h22222222);
    fc_wr(10'h008, 32'h33333333);
    fc_wr(10'h00C, 32'h44444444);
    rd_req(3'd0, 10'h000, 10'h000);
    chk("fc_data", bus.out_data, 128'h44444444_33333333_22222222_11111111);
    chk("fc_is_fc", {127'b0, bus.out_is_fc}, 128'd1);

    // CNN and FC hit bank 2 together; FC held and commits next cycle
    bus.wr_cnn_en = 1'b1; bus.wr_cnn_addr = 10'h083; bus.wr_cnn_data = 32'hAAAA5555;
    bus.wr_fc_en  = 1'b1; bus.wr_fc_addr  = 10'h008; bus.wr_fc_data  = 32'h5A5A5A5A;
    @(negedge clk);
    chk("arb_blocked", {127'b0, bus.wr_fc_ready}, 128'd0);
    tick();
    bus.wr_cnn_en = 1'b0;
    @(negedge clk);
    chk("arb_retry", {127'b0, bus.wr_fc_ready}, 128'd1);
    tick();
    bus.wr_fc_en = 1'b0;
    rd_req(3'd1, 10'h083, 10'h000);
    chk("arb_cnn_data", bus.out_data, 128'hAAAA5555);
    rd_req(3'd0, 10'h000, 10'h000);
    chk("arb_fc_data", bus.out_data, 128'h44444444_5A5A5A5A_22222222_11111111);

    // FC read stalled by a CNN write to another bank
    bus.rd_valid = 1'b1; bus.mode = 3'd0; bus.rd_fc_addr = 10'h000;
    bus.wr_cnn_en = 1'b1; bus.wr_cnn_addr = 10'h005; bus.wr_cnn_data = 32'h0BADF00D;
    @(negedge clk);
    chk("conf_rd_ready", {127'b0, bus.rd_ready}, 128'd0);
    tick();
    bus.wr_cnn_en = 1'b0;
    @(negedge clk);
    chk("conf_accept", {127'b0, bus.rd_ready}, 128'd1);
    tick();
    bus.rd_valid = 1'b0;
    chk("conf_stall_cnt", 128'(bus.stall_cnt), 128'd1);
    chk("conf_fc_data", bus.out_data, 128'h44444444_5A5A5A5A_22222222_11111111);
    drain();

    // Back-pressure: 4 CNN reads with out_ready low
    cnn_wr(10'h0C7, 32'h77777777);
    addrs[0] = 10'h045; addrs[1] = 10'h083; addrs[2] = 10'h005; addrs[3] = 10'h0C7;
    bus.out_ready = 1'b0;
    idx = 0;
    bus.rd_valid = 1'b1; bus.mode = 3'd1; bus.rd_cnn_addr = addrs[0];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.rd_ready) idx++;
      tick();
      if (idx < 4) bus.rd_cnn_addr = addrs[idx];
    end
    chk("bp_accepts", 128'(idx), 128'd2);
    chk("bp_rd_ready", {127'b0, bus.rd_ready}, 128'd0);
    chk("bp_out_valid", {127'b0, bus.out_valid}, 128'd1);
    chk("bp_head", bus.out_data, 128'h04030201);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      @(negedge clk);
      if (bus.rd_ready) idx++;
      tick();
      if (idx < 4) bus.rd_cnn_addr = addrs[idx];
    end
    bus.rd_valid = 1'b0;
    chk("bp_all_accepted", 128'(idx), 128'd4);
    drain();
    chk("bp_stall_cnt", 128'(bus.stall_cnt), 128'(exp_stall));

    // Reset with 2 beats buffered and stalls counted
    bus.out_ready = 1'b0;
    bus.rd_valid = 1'b1; bus.mode = 3'd1; bus.rd_cnn_addr = 10'h045;
    tick();
    bus.rd_cnn_addr = 10'h083;
    tick();
    bus.rd_cnn_addr = 10'h005;
    tick();
    tick();
    chk("pre_rst_stall", 128'(bus.stall_cnt), 128'(exp_stall));
    bus.rd_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    chk("mid_rst_stall", 128'(bus.stall_cnt), 128'd0);
    chk("mid_rst_out_data", bus.out_data, 128'd0);
    tick();
    tick();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_out_valid", {127'b0, bus.out_valid}, 128'd0);
    rd_req(3'd1, 10'h045, 10'h000);
    chk("post_rst_data", bus.out_data, 128'h04030201);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
